// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants, RV32I opcodes and fetch state encoding.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_FULL
  } fetch_state_e;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction memory request/response channel.
interface instruction_fetch_unit_if;
  logic                        imem_req_valid;
  logic [riscv_pkg::XLEN-1:0]  imem_req_addr;
  logic                        imem_req_ready;
  logic                        imem_rsp_valid;
  logic [31:0]                 imem_rsp_data;
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner, single-outstanding imem fetch, skid-buffered IF/ID register.
module instruction_fetch_unit #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic                    clk,
  input  logic                    rst,
  instruction_fetch_unit_if.master imem,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  input  logic                    stall,
  output logic                    id_valid,
  output logic [31:0]             id_instruction,
  output logic [6:0]              id_opcode,
  output logic [XLEN-1:0]         id_pc,
  output logic [XLEN-1:0]         id_pc_plus4,
  output logic                    id_illegal
);
  import riscv_pkg::*;
  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_skid_pc;
  logic [31:0]     r_skid;
  logic            r_drop;
  logic            r_id_valid;
  logic [31:0]     r_id_instr;
  logic [XLEN-1:0] r_id_pc;
  logic [XLEN-1:0] r_id_pc4;
  logic            w_id_free;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_redirect_aligned;
  assign w_id_free          = !r_id_valid || !stall;
  assign w_pc4              = r_pc + XLEN'(4);
  assign w_redirect_aligned = redirect_pc & ~XLEN'(3);
  assign imem.imem_req_valid = r_state == FETCH_REQ;
  assign imem.imem_req_addr  = r_pc;
  assign id_valid       = r_id_valid;
  assign id_instruction = r_id_instr;
  assign id_opcode      = r_id_instr[6:0];
  assign id_pc          = r_id_pc;
  assign id_pc_plus4    = r_id_pc4;
  assign id_illegal     = r_id_valid && (r_id_instr[1:0] != 2'b11);
  // A redirect in WAIT without a response arms r_drop so the in-flight word is discarded later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FETCH_IDLE;
      r_pc       <= RESET_PC;
      r_skid     <= NOP_INSTR;
      r_skid_pc  <= RESET_PC;
      r_drop     <= 1'b0;
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
      r_id_pc    <= RESET_PC;
      r_id_pc4   <= RESET_PC + XLEN'(4);
    end else begin
      if (!stall) r_id_valid <= 1'b0;
      if (redirect_valid) begin
        r_pc       <= w_redirect_aligned;
        r_id_valid <= 1'b0;
        r_skid     <= NOP_INSTR;
        r_drop     <= (r_state == FETCH_WAIT) && !imem.imem_rsp_valid;
        r_state    <= (r_state == FETCH_WAIT && !imem.imem_rsp_valid) ? FETCH_WAIT : FETCH_REQ;
      end else begin
        case (r_state)
          FETCH_IDLE: r_state <= FETCH_REQ;
          FETCH_REQ:  if (imem.imem_req_ready) r_state <= FETCH_WAIT;
          FETCH_WAIT: if (imem.imem_rsp_valid) begin
            r_drop  <= 1'b0;
            r_state <= FETCH_REQ;
            if (!r_drop && w_id_free) begin
              r_id_valid <= 1'b1;
              r_id_instr <= imem.imem_rsp_data;
              r_id_pc    <= r_pc;
              r_id_pc4   <= w_pc4;
              r_pc       <= w_pc4;
            end else if (!r_drop) begin
              r_skid    <= imem.imem_rsp_data;
              r_skid_pc <= r_pc;
              r_pc      <= w_pc4;
              r_state   <= FETCH_FULL;
            end
          end
          FETCH_FULL: if (!stall) begin
            r_id_valid <= 1'b1;
            r_id_instr <= r_skid;
            r_id_pc    <= r_skid_pc;
            r_id_pc4   <= r_skid_pc + XLEN'(4);
            r_state    <= FETCH_REQ;
          end
          default: r_state <= FETCH_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench; stimulus queues expected IF/ID words, a monitor checks each consumed word.
module tb_instruction_fetch_unit;
  import riscv_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        id_valid, id_illegal;
  logic [31:0] id_instruction, id_pc, id_pc_plus4;
  logic [6:0]  id_opcode;
  instruction_fetch_unit_if imem();
  instruction_fetch_unit dut (
    .clk(clk), .rst(rst), .imem(imem),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .id_valid(id_valid), .id_instruction(id_instruction), .id_opcode(id_opcode),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_illegal(id_illegal)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h200) ? 32'h1234_5670 : (32'h0050_0093 ^ {a[24:0], 7'b0});
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic expect_fetch(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    e.instr = mem_word(pc);
    q.push_back(e);
  endtask
  task automatic wait_req(input logic [31:0] a);
    bit hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      hit = imem.imem_req_valid && imem.imem_req_addr == a;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_req: no request to %h within 40 cycles", a);
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask
  // Memory model: one response mem_lat cycles after acceptance, held for one cycle.
  bit          acc, pend;
  int          cnt;
  logic [31:0] acc_addr, pend_addr;
  initial begin
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'h0;
    pend = 0;
    forever begin
      @(posedge clk);
      acc = imem.imem_req_valid && imem.imem_req_ready && !rst;
      acc_addr = imem.imem_req_addr;
      #1;
      imem.imem_rsp_valid = 1'b0;
      if (acc) begin
        pend = 1;
        cnt = mem_lat;
        pend_addr = acc_addr;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem.imem_rsp_valid = 1'b1;
          imem.imem_rsp_data  = mem_word(pend_addr);
          pend = 0;
        end
      end
    end
  end
  // Monitor: a word is consumed by decode on every cycle with id_valid and no stall.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && id_valid && !stall) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_id: got pc %h instr %h, expected no instruction", id_pc, id_instruction);
        end else begin
          e = q.pop_front();
          chk("id_instruction", id_instruction, e.instr);
          chk("id_pc", id_pc, e.pc);
          chk("id_opcode", {25'b0, id_opcode}, {25'b0, e.instr[6:0]});
          chk("id_pc_plus4", id_pc_plus4, e.pc + 32'd4);
          chk("id_illegal", {31'b0, id_illegal}, {31'b0, e.instr[1:0] != 2'b11});
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    imem.imem_req_ready = 1'b1;
    @(negedge clk);
    chk("rst_req_valid", {31'b0, imem.imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem.imem_req_addr, RESET_PC);
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_id_instruction", id_instruction, NOP_INSTR);
    chk("rst_id_pc", id_pc, RESET_PC);
    chk("rst_id_pc_plus4", id_pc_plus4, RESET_PC + 32'd4);
    chk("rst_id_illegal", {31'b0, id_illegal}, 32'd0);
    // Streaming fetch of 0, 4, 8 with a zero-wait memory
    expect_fetch(32'h0);
    expect_fetch(32'h4);
    expect_fetch(32'h8);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("first_cycle_req_valid", {31'b0, imem.imem_req_valid}, 32'd0);
    wait_req(32'hC);
    imem.imem_req_ready = 1'b0;
    drain();
    // Stall: 12 held in IF/ID while 16 is parked in the skid register
    expect_fetch(32'hC);
    expect_fetch(32'h10);
    @(posedge clk); #1;
    stall = 1'b1;
    imem.imem_req_ready = 1'b1;
    wait_req(32'h10);
    @(posedge clk); #1 imem.imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_id_valid", {31'b0, id_valid}, 32'd1);
      chk("stall_id_instruction", id_instruction, mem_word(32'hC));
      chk("stall_id_pc", id_pc, 32'hC);
      chk("stall_req_valid", {31'b0, imem.imem_req_valid}, 32'd0);
    end
    @(posedge clk); #1 stall = 1'b0;
    drain();
    // Redirect in WAIT, response two cycles after acceptance is discarded
    @(posedge clk); #1;
    mem_lat = 2;
    imem.imem_req_ready = 1'b1;
    @(posedge clk); #1;
    imem.imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("drop_wait_id_valid", {31'b0, id_valid}, 32'd0);
    chk("drop_wait_req_valid", {31'b0, imem.imem_req_valid}, 32'd0);
    @(negedge clk);
    chk("drop_req_valid", {31'b0, imem.imem_req_valid}, 32'd1);
    chk("drop_req_addr", imem.imem_req_addr, 32'h100);
    chk("drop_id_valid", {31'b0, id_valid}, 32'd0);
    // Redirect coincident with a response while stalled
    @(posedge clk); #1;
    mem_lat = 1;
    stall = 1'b1;
    imem.imem_req_ready = 1'b1;
    wait_req(32'h104);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    imem.imem_req_ready = 1'b0;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    chk("coinc_id_valid", {31'b0, id_valid}, 32'd0);
    chk("coinc_req_valid", {31'b0, imem.imem_req_valid}, 32'd1);
    chk("coinc_req_addr", imem.imem_req_addr, 32'h200);
    expect_fetch(32'h200);
    @(posedge clk); #1 imem.imem_req_ready = 1'b1;
    wait_req(32'h204);
    imem.imem_req_ready = 1'b0;
    drain();
    // Misaligned redirect near the top of the address space, then wrap
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_req_valid", {31'b0, imem.imem_req_valid}, 32'd1);
    chk("wrap_req_addr", imem.imem_req_addr, 32'hFFFF_FFFC);
    expect_fetch(32'hFFFF_FFFC);
    expect_fetch(32'h0);
    @(posedge clk); #1 imem.imem_req_ready = 1'b1;
    wait_req(32'h4);
    imem.imem_req_ready = 1'b0;
    drain();
    // Reset during WAIT with a stale response after release
    @(posedge clk); #1;
    mem_lat = 3;
    imem.imem_req_ready = 1'b1;
    @(posedge clk); #1;
    imem.imem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_req_valid", {31'b0, imem.imem_req_valid}, 32'd0);
    chk("midrst_req_addr", imem.imem_req_addr, RESET_PC);
    chk("midrst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("midrst_id_instruction", id_instruction, NOP_INSTR);
    chk("midrst_id_pc", id_pc, RESET_PC);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stale_id_valid", {31'b0, id_valid}, 32'd0);
      chk("stale_id_illegal", {31'b0, id_illegal}, 32'd0);
    end
    chk("stale_req_valid", {31'b0, imem.imem_req_valid}, 32'd1);
    chk("stale_req_addr", imem.imem_req_addr, RESET_PC);
    expect_fetch(RESET_PC);
    @(posedge clk); #1;
    mem_lat = 1;
    imem.imem_req_ready = 1'b1;
    wait_req(RESET_PC + 32'd4);
    imem.imem_req_ready = 1'b0;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
